controlador_contador: RTL
=========================

Name: controlador_contador

Overview:
- Sequencer for the D-flip-flop up-counter datapath: start, pause, abort and terminal-count detection around a loadable counter.
- A one-cycle start launches a count from 0 to a limit that is sampled at start.
- The limit is reached in one-shot or cyclic mode; busy, state and end-of-count status are reported.
- Sits between control logic (or a testbench) and the counter register. Internal counter width is parameterisable.

Parameters:
- ANCHO, 4, width of the count and of the limit.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_inicio  input  1  start request; honoured only in REPOSO.
- i_pausa  input  1  level; holds the count while high.
- i_abortar  input  1  returns to REPOSO and clears the count.
- i_ciclico  input  1  sampled at start; 1 = wrap to 0 and keep counting.
- i_limite  input  ANCHO  terminal value; sampled at start.
- o_cuenta  output  ANCHO  current count (registered).
- o_ocupado  output  1  high in CONTANDO, PAUSA and FIN.
- o_fin  output  1  one-cycle end-of-count pulse (registered).
- o_estado  output  2  REPOSO=0, CONTANDO=1, PAUSA=2, FIN=3.

Behaviour:
- One clock, i_clk. Reset is synchronous, active-high on i_rst. All state changes occur on the rising edge.
- Reset: state REPOSO; o_cuenta=0, o_ocupado=0, o_fin=0, o_estado=0; limit and mode registers cleared.
- Priority each edge: i_rst > i_abortar > i_pausa > terminal detect > increment.
- REPOSO:
  - i_inicio=1 at edge k: latch i_limite and i_ciclico, set o_cuenta=0, go to CONTANDO.
  - o_ocupado is 1 after edge k.
  - Otherwise o_cuenta holds its last value.
- CONTANDO:
  - i_pausa=1: go to PAUSA; count unchanged.
  - o_cuenta != limit: o_cuenta+1.
  - o_cuenta == limit, non-cyclic: go to FIN; count holds at the limit; o_fin=1 for the next cycle.
  - o_cuenta == limit, cyclic: o_cuenta<=0, stay in CONTANDO, o_fin=1 for the next cycle.
- PAUSA: hold the count. i_pausa=0 returns to CONTANDO; counting resumes the following edge.
- FIN: lasts exactly one cycle, with o_fin=1. Then REPOSO, o_fin=0, count held.
- Latency, limit L, start at edge k:
  - o_cuenta=n after edge k+n, for n≤L.
  - After edge k+L+1: FIN/o_fin=1 (one-shot), or o_cuenta=0 with o_fin=1 (cyclic).
  - After edge k+L+2: one-shot returns to REPOSO.
- Boundary rules:
  - L=0: FIN one edge after start.
  - L=2^ANCHO-1: the full range is counted with no overflow; +1 is never taken at the limit.
  - i_inicio while busy: ignored; latched limit and mode unchanged.
  - i_inicio with i_abortar in REPOSO: abort wins; stay in REPOSO.
  - i_pausa and terminal on the same edge: pause wins; terminal is evaluated after resume.
  - i_abortar in any state: REPOSO, o_cuenta=0, o_fin=0.
  - Reset mid-count: identical to the reset values above.

Optional Feature:
- Macro CONTADOR_DESCENDENTE_EN.
- Defined:
  - Adds input i_descendente (1 bit), sampled at start.
  - When it is 1: start loads o_cuenta=limit, each CONTANDO edge decrements, terminal is o_cuenta==0, and cyclic wrap reloads the limit.
  - o_fin timing is identical to up-counting.
- Undefined: the port is absent; up-count only.

Decomposition:
- Shared include controlador_contador_defs.vh holds:
  - state encodings EST_REPOSO, EST_CONTANDO, EST_PAUSA, EST_FIN (2 bits);
  - default width ANCHO_CUENTA=4.
- Sub-module contador_ud: registered counter with clear, load value, enable and direction. The FSM in controlador_contador drives it.

Test Plan:
- Reset asserted 2 cycles mid-count at o_cuenta=5 -> next edge o_cuenta=0, o_estado=0, o_ocupado=0, o_fin=0.
- i_limite=3, i_ciclico=0, i_inicio pulse -> o_cuenta 0,1,2,3,3; o_fin=1 only in the FIN cycle; REPOSO after; o_ocupado low after 6 edges.
- i_limite=2, i_ciclico=1 -> o_cuenta 0,1,2,0,1,2,0; o_fin pulses on each 2->0 wrap; o_ocupado stays 1.
- Count to 2, then i_pausa high 3 cycles -> o_cuenta held at 2, o_estado=2; on release o_cuenta 3 after two edges; i_inicio during pause ignored.
- i_abortar at o_cuenta=7 (limit 15) -> REPOSO, o_cuenta=0; i_limite=0 start -> FIN one edge after start, o_fin single pulse.
- With CONTADOR_DESCENDENTE_EN, i_descendente=1, i_limite=4 -> o_cuenta 4,3,2,1,0 then FIN, o_fin=1 one cycle.

Source files
------------

// File: rtl/controlador_contador_pkg.sv
// controlador_contador_pkg: shared state encodings and default count width
package controlador_contador_pkg;
  localparam int ANCHO_CUENTA = 4;
  typedef enum logic [1:0] {
    EST_REPOSO   = 2'd0,
    EST_CONTANDO = 2'd1,
    EST_PAUSA    = 2'd2,
    EST_FIN      = 2'd3
  } estado_t;
endpackage

// File: rtl/controlador_contador_ud.sv
// contador_ud: registered up/down counter with clear, load and enable (clear > load > enable)
module contador_ud #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic         down,
  input  logic [W-1:0] valor,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : load ? valor : en ? (down ? q - 1'b1 : q + 1'b1) : q;
endmodule

// File: rtl/controlador_contador.sv
// controlador_contador: start/pause/abort/terminal sequencer around contador_ud
// Optional down-counting is enabled by defining CONTADOR_DESCENDENTE_EN.
module controlador_contador
  import controlador_contador_pkg::*;
#(
  parameter int ANCHO = ANCHO_CUENTA
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inicio,
  input  logic             i_pausa,
  input  logic             i_abortar,
  input  logic             i_ciclico,
`ifdef CONTADOR_DESCENDENTE_EN
  input  logic             i_descendente,
`endif
  input  logic [ANCHO-1:0] i_limite,
  output logic [ANCHO-1:0] o_cuenta,
  output logic             o_ocupado,
  output logic             o_fin,
  output logic [1:0]       o_estado
);
  estado_t          estado, estado_sig;
  logic [ANCHO-1:0] limite, cuenta;
  logic             ciclico, fin, desc, desc_in;
  logic             inicio_ok, contar, terminal, wrap;
`ifdef CONTADOR_DESCENDENTE_EN
  assign desc_in = i_descendente;
  always_ff @(posedge i_clk)
    if (i_rst) desc <= 1'b0;
    else if (inicio_ok) desc <= i_descendente;
`else
  assign desc_in = 1'b0;
  assign desc    = 1'b0;
`endif
  assign inicio_ok = (estado == EST_REPOSO) && i_inicio && !i_abortar;
  assign contar    = (estado == EST_CONTANDO) && !i_abortar && !i_pausa;
  assign terminal  = cuenta == (desc ? '0 : limite);
  assign wrap      = contar && terminal && ciclico;
  always_comb begin
    estado_sig = i_abortar ? EST_REPOSO :
                 (estado == EST_REPOSO)   ? (i_inicio ? EST_CONTANDO : EST_REPOSO) :
                 (estado == EST_CONTANDO) ? (i_pausa ? EST_PAUSA :
                                             (terminal && !ciclico) ? EST_FIN : EST_CONTANDO) :
                 (estado == EST_PAUSA)    ? (i_pausa ? EST_PAUSA : EST_CONTANDO) :
                                            EST_REPOSO;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      estado  <= EST_REPOSO;
      limite  <= '0;
      ciclico <= 1'b0;
      fin     <= 1'b0;
    end else begin
      estado <= estado_sig;
      fin    <= contar && terminal;
      if (inicio_ok) begin
        limite  <= i_limite;
        ciclico <= i_ciclico;
      end
    end
  // Down mode starts and wraps by loading the limit; up mode does both by clearing.
  contador_ud #(.W(ANCHO)) u_cnt (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (i_abortar || (inicio_ok && !desc_in) || (wrap && !desc)),
    .load ((inicio_ok && desc_in) || (wrap && desc)),
    .en   (contar && !terminal),
    .down (desc),
    .valor(inicio_ok ? i_limite : limite),
    .q    (cuenta)
  );
  assign o_cuenta  = cuenta;
  assign o_ocupado = estado != EST_REPOSO;
  assign o_fin     = fin;
  assign o_estado  = estado;
endmodule
